axi4_lite_manager: RTL and testbench
====================================

Name: axi4_lite_manager

Overview:
- Bus-manager stage directly upstream of the axi4_lite subordinate: converts a simple valid/ready command stream (register read/write requests) into AXI4-Lite transactions and returns a valid/ready response stream.
- One transaction outstanding at a time; write address and write data are issued together, and each channel completes its handshake independently.
- Misaligned requests are rejected locally and never reach the bus.

Parameters:
- DATA_WIDTH, 32, width of data buses (32 or 64).
- ADDR_WIDTH, 32, width of address buses.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and rejects)
- rsp_resp  out  2  AXI response code
- m_axi_awaddr  out  ADDR_WIDTH;  m_axi_awvalid  out  1;  m_axi_awready  in  1
- m_axi_wdata  out  DATA_WIDTH;  m_axi_wvalid  out  1;  m_axi_wready  in  1
- m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1
- m_axi_araddr  out  ADDR_WIDTH;  m_axi_arvalid  out  1;  m_axi_arready  in  1
- m_axi_rdata  in  DATA_WIDTH;  m_axi_rresp  in  2;  m_axi_rvalid  in  1;  m_axi_rready  out  1

Behaviour:
- Single clock aclk. Reset aresetn is asynchronous and active-low.
- Reset values: all valid/ready outputs 0. Exception: cmd_ready = 1 (IDLE). Address, data, rsp_resp and rsp_rdata registers = 0.
- All outputs are registered.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, capture cmd_* in the cycle of the handshake.
  - Misalign check: cmd_addr[log2(DATA_WIDTH/8)-1:0] != 0 -> RSP with rsp_resp = SLVERR (2'b10), rsp_rdata = 0. No AXI valid is asserted.
  - Aligned write -> WR. Aligned read -> RD_ADDR.
- WR:
  - awvalid and wvalid rise in the first cycle after acceptance.
  - Each valid drops in the cycle after its own ready handshake. The other is held until its own handshake.
  - Handshakes may occur in the same cycle or in either order.
  - Leave WR when both are done. bready = 1 only in WR_RESP.
- WR_RESP: on bvalid & bready, capture bresp -> RSP.
- RD_ADDR: arvalid held until arready -> RD_DATA.
- RD_DATA: rready = 1; on rvalid, capture rdata and rresp -> RSP.
- RSP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On the handshake -> IDLE; cmd_ready = 1 in the next cycle.
- Minimum latency, command accept to rsp_valid, with zero-wait subordinate: write 3 cycles, read 3 cycles, misaligned reject 1 cycle.
- AXI rules:
  - A valid is never deasserted before its ready.
  - Address and data are stable while valid is high.
  - bready and rready are never asserted outside their states.
- Responses OKAY, EXOKAY, SLVERR and DECERR are passed through unmodified.
- Reset mid-operation: all AXI valids and readies and rsp_valid go low immediately (asynchronously); FSM -> IDLE. The in-flight transaction is dropped with no response.
- cmd_valid while not in IDLE is ignored (cmd_ready = 0).

Decomposition:
- Shared package axi4_lite_pkg holds:
  - resp_t enum: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - mgr_state_t enum for the FSM states.
  - Helper function for byte-lane address LSB width.
- No sub-module is needed. The aw/w "done" flags are two local registers within the single module.

Test Plan:
- Reset for 20 us, release; read 0x00 -> rsp_valid, rsp_resp = OKAY, rsp_rdata = 0x0, rsp_write = 0.
- Write 0x04 = 0xADADABAB, then read 0x04 -> write rsp OKAY; read rsp_rdata = 0xADADABAB.
- Subordinate model delays wready 5 cycles after awready (and vice versa) -> awvalid drops 1 cycle after awready; wvalid held until wready; exactly one B accepted; rsp OKAY.
- Command to 0x02 -> rsp_resp = SLVERR one cycle later; no awvalid, wvalid or arvalid pulses.
- Hold rsp_ready = 0 for 10 cycles -> rsp_valid and rsp_* stable; cmd_ready stays 0; accepted 1 cycle after rsp_ready.
- Assert aresetn = 0 while awvalid = 1 -> all valids 0 in the same cycle; after release, cmd_ready = 1 and read 0x00 returns 0x0.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite manager: response codes, FSM states and
// the byte-lane helper used by the alignment check.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } mgr_state_t;

    // Number of address LSBs that select a byte lane within one data beat.
    function automatic int addr_lsb_width(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi4_lite_manager.sv
// Command-stream to AXI4-Lite manager. One transaction in flight; every
// output comes straight from a flop.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// WR      | awvalid/wvalid issued, each dropped after its own handshake
// WR_RESP | bready high, waiting for the write response
// RD_ADDR | arvalid held until arready
// RD_DATA | rready high, waiting for read data
// RSP     | rsp_valid high, rsp_* held until rsp_ready
module axi4_lite_manager
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int ADDR_LSB = addr_lsb_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);

    mgr_state_t state_q, state_d;
    logic aw_done_q, aw_done_d;
    logic w_done_q, w_done_d;

    logic cmd_ready_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, rsp_valid_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
    logic misaligned;

    assign cmd_hs  = cmd_valid & cmd_ready;
    assign aw_hs   = m_axi_awvalid & m_axi_awready;
    assign w_hs    = m_axi_wvalid & m_axi_wready;
    assign b_hs    = m_axi_bvalid & m_axi_bready;
    assign ar_hs   = m_axi_arvalid & m_axi_arready;
    assign r_hs    = m_axi_rvalid & m_axi_rready;
    assign rsp_hs  = rsp_valid & rsp_ready;

    assign misaligned = (cmd_addr & LSB_MASK) != '0;

    // Both address channels share the captured command address.
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign rsp_write    = write_q;

    // State, per-channel done flags and registered handshake outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            cmd_ready     <= 1'b1;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
        end else begin
            state_q       <= state_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            cmd_ready     <= cmd_ready_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
            rsp_valid     <= rsp_valid_d;
        end
    end

    // Next state, then output values derived from where the FSM is heading
    // so that every output is available straight from a flop.
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    if (misaligned) begin
                        state_d = RSP;
                    end else if (cmd_write) begin
                        state_d   = WR;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            WR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: if (b_hs)   state_d = RSP;
            RD_ADDR: if (ar_hs)  state_d = RD_DATA;
            RD_DATA: if (r_hs)   state_d = RSP;
            RSP:     if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        awvalid_d   = (state_d == WR) && !aw_done_d;
        wvalid_d    = (state_d == WR) && !w_done_d;
        bready_d    = (state_d == WR_RESP);
        arvalid_d   = (state_d == RD_ADDR);
        rready_d    = (state_d == RD_DATA);
        rsp_valid_d = (state_d == RSP);
    end

    // Command capture and response datapath; rdata stays zero for writes
    // and rejects because it is cleared on every accepted command.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= OKAY;
        end else begin
            if (cmd_hs) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                write_q   <= cmd_write;
                rsp_rdata <= '0;
                rsp_resp  <= misaligned ? SLVERR : OKAY;
            end
            if (b_hs) begin
                rsp_resp <= m_axi_bresp;
            end
            if (r_hs) begin
                rsp_rdata <= m_axi_rdata;
                rsp_resp  <= m_axi_rresp;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_manager.sv
// Directed bench for axi4_lite_manager with a reactive subordinate model
// and a scoreboard of expected responses.
module tb_axi4_lite_manager;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    axi4_lite_manager #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct {
        logic        w;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   accept_cyc = 0;

    // Subordinate knobs set by the stimulus.
    int         aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0] next_bresp = 2'b00, next_rresp = 2'b00;

    logic [31:0] ref_mem [16] = '{default: 32'h0};
    logic [31:0] sub_mem [16] = '{default: 32'h0};

    // Monitor state (updated at posedge).
    int          cyc = 0;
    int          aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0, valid_cyc = 0, proto_err = 0;
    logic        aw_got = 0, w_got = 0, b_pending = 0, r_pending = 0;
    logic [31:0] aw_addr_c = 0, w_data_c = 0, r_data_c = 0;
    logic        aw_pend_p = 0, w_pend_p = 0, ar_pend_p = 0;
    logic        aw_hs_p = 0, w_hs_p = 0;
    logic [31:0] aw_addr_p = 0, w_data_p = 0, ar_addr_p = 0;

    wire aw_hs = m_axi_awvalid & m_axi_awready;
    wire w_hs  = m_axi_wvalid & m_axi_wready;
    wire ar_hs = m_axi_arvalid & m_axi_arready;

    // Bus monitor: handshake bookkeeping, subordinate storage, protocol rules.
    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (!aresetn) begin
            aw_got <= 0; w_got <= 0; b_pending <= 0; r_pending <= 0;
            aw_pend_p <= 0; w_pend_p <= 0; ar_pend_p <= 0; aw_hs_p <= 0; w_hs_p <= 0;
        end else begin
            if (aw_hs) begin
                aw_hs_cnt <= aw_hs_cnt + 1; aw_hs_cyc <= cyc;
                aw_got <= 1; aw_addr_c <= m_axi_awaddr;
            end
            if (w_hs) begin
                w_hs_cnt <= w_hs_cnt + 1; w_hs_cyc <= cyc;
                w_got <= 1; w_data_c <= m_axi_wdata;
            end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                sub_mem[aw_hs ? m_axi_awaddr[5:2] : aw_addr_c[5:2]] <= w_hs ? m_axi_wdata : w_data_c;
                b_pending <= 1; aw_got <= 0; w_got <= 0;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pending <= 0; b_hs_cnt <= b_hs_cnt + 1;
            end
            if (ar_hs) begin
                ar_hs_cnt <= ar_hs_cnt + 1; r_pending <= 1; r_data_c <= sub_mem[m_axi_araddr[5:2]];
            end
            if (m_axi_rvalid && m_axi_rready) r_pending <= 0;
            if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) valid_cyc <= valid_cyc + 1;
            if (aw_pend_p && (!m_axi_awvalid || m_axi_awaddr !== aw_addr_p)) proto_err <= proto_err + 1;
            if (w_pend_p && (!m_axi_wvalid || m_axi_wdata !== w_data_p)) proto_err <= proto_err + 1;
            if (ar_pend_p && (!m_axi_arvalid || m_axi_araddr !== ar_addr_p)) proto_err <= proto_err + 1;
            if ((aw_hs_p && m_axi_awvalid) || (w_hs_p && m_axi_wvalid)) proto_err <= proto_err + 1;
            aw_pend_p <= m_axi_awvalid && !m_axi_awready;
            w_pend_p  <= m_axi_wvalid && !m_axi_wready;
            ar_pend_p <= m_axi_arvalid && !m_axi_arready;
            aw_hs_p   <= aw_hs;
            w_hs_p    <= w_hs;
            aw_addr_p <= m_axi_awaddr;
            w_data_p  <= m_axi_wdata;
            ar_addr_p <= m_axi_araddr;
        end
    end

    // Subordinate drive: readies after a programmable wait, responses from pending flags.
    initial begin
        int aw_wait, w_wait, ar_wait;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
            end else begin
                if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= aw_delay); aw_wait++; end
                else begin m_axi_awready = 0; aw_wait = 0; end
                if (m_axi_wvalid) begin m_axi_wready = (w_wait >= w_delay); w_wait++; end
                else begin m_axi_wready = 0; w_wait = 0; end
                if (m_axi_arvalid) begin m_axi_arready = (ar_wait >= ar_delay); ar_wait++; end
                else begin m_axi_arready = 0; ar_wait = 0; end
                m_axi_bvalid = b_pending; m_axi_bresp = next_bresp;
                m_axi_rvalid = r_pending; m_axi_rdata = r_data_c; m_axi_rresp = next_rresp;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Push the expected response, then present the command until accepted.
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input int lat);
        exp_t e;
        int   n;
        e.w = w; e.lat = lat;
        if (a[1:0] != 2'b00) begin
            e.rdata = 0; e.resp = 2'b10;
        end else if (w) begin
            e.rdata = 0; e.resp = next_bresp; ref_mem[a[5:2]] = d;
        end else begin
            e.rdata = ref_mem[a[5:2]]; e.resp = next_rresp;
        end
        sb.push_back(e);
        @(negedge aclk);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge aclk); n++; end
        check("cmd accepted", cmd_ready, 1'b1);
        @(posedge aclk);
        #1;
        accept_cyc = cyc;
        cmd_valid = 0;
    endtask

    // Wait for the response, optionally stall it, compare with the scoreboard.
    task automatic get_rsp(input int hold, input string tag);
        exp_t        e;
        int          n, lat, unstable;
        logic [31:0] rd0;
        logic [1:0]  rs0;
        logic        w0;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s scoreboard: observed=empty expected=entry", tag);
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        n = 0;
        @(negedge aclk);
        while (!rsp_valid && n < 200) begin @(negedge aclk); n++; end
        check({tag, " rsp_valid"}, rsp_valid, 1'b1);
        if (!rsp_valid) return;
        lat = cyc - accept_cyc + 1;
        if (e.lat >= 0) check({tag, " latency"}, lat, e.lat);
        rd0 = rsp_rdata; rs0 = rsp_resp; w0 = rsp_write; unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            if (!rsp_valid || cmd_ready || rsp_rdata !== rd0 || rsp_resp !== rs0 || rsp_write !== w0)
                unstable++;
        end
        if (hold > 0) check({tag, " held stable"}, unstable, 0);
        check({tag, " rsp_write"}, rsp_write, e.w);
        check({tag, " rsp_rdata"}, rsp_rdata, e.rdata);
        check({tag, " rsp_resp"}, rsp_resp, e.resp);
        rsp_ready = 1;
        @(posedge aclk);
        #1;
        rsp_ready = 0;
        @(negedge aclk);
        check({tag, " released"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        int b0, aw0, w0, v0;
        aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;

        #100;
        check("reset cmd_ready", cmd_ready, 1'b1);
        check("reset valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}, 6'b0);
        check("reset rsp regs", {rsp_rdata, rsp_resp}, 34'h0);
        check("reset addr regs", {m_axi_awaddr, m_axi_wdata}, 64'h0);
        #20us;
        @(negedge aclk);
        aresetn = 1;

        send_cmd(0, 32'h00, 32'h0, 3);
        get_rsp(0, "rd 0x00");

        aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
        send_cmd(1, 32'h04, 32'hADADABAB, 3);
        get_rsp(0, "wr 0x04");
        check("wr 0x04 handshakes", {8'(aw_hs_cnt - aw0), 8'(w_hs_cnt - w0), 8'(b_hs_cnt - b0)}, 24'h010101);
        send_cmd(0, 32'h04, 32'h0, 3);
        get_rsp(0, "rd 0x04");

        aw_delay = 0; w_delay = 5; b0 = b_hs_cnt;
        send_cmd(1, 32'h08, 32'h12345678, -1);
        get_rsp(0, "wr late w");
        check("late w gap", w_hs_cyc - aw_hs_cyc, 5);
        check("late w b count", b_hs_cnt - b0, 1);

        aw_delay = 5; w_delay = 0; b0 = b_hs_cnt;
        send_cmd(1, 32'h0C, 32'hCAFEF00D, -1);
        get_rsp(0, "wr late aw");
        check("late aw gap", aw_hs_cyc - w_hs_cyc, 5);
        check("late aw b count", b_hs_cnt - b0, 1);
        aw_delay = 0; w_delay = 0;

        next_rresp = 2'b01;
        send_cmd(0, 32'h08, 32'h0, 3);
        get_rsp(0, "rd exokay");
        next_bresp = 2'b10;
        send_cmd(1, 32'h10, 32'h5A5A0001, 3);
        get_rsp(0, "wr slverr");
        next_rresp = 2'b11;
        send_cmd(0, 32'h0C, 32'h0, 3);
        get_rsp(0, "rd decerr");
        next_bresp = 2'b00; next_rresp = 2'b00;

        v0 = valid_cyc;
        send_cmd(1, 32'h02, 32'hFFFFFFFF, 1);
        get_rsp(0, "misaligned wr");
        send_cmd(0, 32'h06, 32'h0, 1);
        get_rsp(0, "misaligned rd");
        check("misaligned bus quiet", valid_cyc - v0, 0);

        send_cmd(0, 32'h04, 32'h0, 3);
        get_rsp(10, "rsp stall");

        aw_delay = 50;
        send_cmd(1, 32'h14, 32'h77777777, -1);
        check("awvalid before reset", m_axi_awvalid, 1'b1);
        #2;
        aresetn = 0;
        #1;
        check("mid-op reset valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}, 6'b0);
        check("mid-op reset cmd_ready", cmd_ready, 1'b1);
        repeat (3) @(negedge aclk);
        aresetn = 1;
        sb.delete();
        aw_delay = 0;
        @(negedge aclk);
        check("post-reset cmd_ready", cmd_ready, 1'b1);
        send_cmd(0, 32'h00, 32'h0, 3);
        get_rsp(0, "rd after reset");

        repeat (3) @(negedge aclk);
        check("protocol violations", proto_err, 0);
        check("scoreboard drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
